// File: rtl/core_run_ctrl.sv
`default_nettype none
// core_run_ctrl: run/halt/step clock-enable gating for Synchronous_Core with a retire-trace FIFO.
// Optional feature macro BREAKPOINT_EN adds a PC breakpoint (bp_en, bp_addr, bp_hit).
module core_run_ctrl #(
  parameter int XLEN          = 32,
  parameter int DEPTH         = 16,
  parameter int CNT_W         = 32,
  parameter int STALL_ON_FULL = 0
) (
  input  logic                     clk,
  input  logic                     Reset,
  input  logic                     run_req,
  input  logic                     halt_req,
  input  logic                     step_req,
  output logic                     core_en,
  input  logic [XLEN-1:0]          core_pc,
  input  logic [XLEN-1:0]          core_out,
  input  logic [XLEN-1:0]          core_file,
  output logic                     trc_valid,
  input  logic                     trc_ready,
  output logic [3*XLEN-1:0]        trc_data,
  output logic [$clog2(DEPTH):0]   trc_count,
  output logic                     trc_overflow,
  output logic [CNT_W-1:0]         retired,
  output logic [1:0]               run_state
`ifdef BREAKPOINT_EN
  ,
  input  logic                     bp_en,
  input  logic [XLEN-1:0]          bp_addr,
  output logic                     bp_hit
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_accept;

  logic [3*XLEN-1:0]   r_mem [DEPTH];
  logic [AW:0]         r_wr;
  logic [AW:0]         r_rd;
  logic [CNT_W-1:0]    r_retired;
  logic                r_overflow;

  logic                w_full;
  logic                w_empty;
  logic                w_pop;
  logic                w_push;
  logic                w_drop;
  logic                w_active;
  logic                w_stall;
  logic                w_bp;

  assign w_empty  = (r_wr == r_rd);
  assign w_full   = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop    = !w_empty && trc_ready;
  assign w_active = (r_state == ST_RUN) || (r_state == ST_STEP);
  // A pending pop frees the slot this cycle, so a full FIFO only stalls without trc_ready.
  assign w_stall  = (STALL_ON_FULL != 0) && w_full && !trc_ready;
  assign core_en  = w_active && !w_stall;
  assign w_push   = core_en && (!w_full || w_pop);
  assign w_drop   = core_en && w_full && !w_pop;

`ifdef BREAKPOINT_EN
  logic r_bp_hit;
  assign w_bp   = core_en && bp_en && (core_pc == bp_addr);
  assign bp_hit = r_bp_hit;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_bp_hit <= 1'b0;
    end else if (w_bp) begin
      r_bp_hit <= 1'b1;
    end else if (w_accept) begin
      r_bp_hit <= 1'b0;
    end
  end
`else
  assign w_bp = 1'b0;
`endif

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      ST_HALTED: begin
        if (halt_req) begin
          w_next = ST_HALTED;
        end else if (step_req) begin
          w_next   = ST_STEP;
          w_accept = 1'b1;
        end else if (run_req) begin
          w_next   = ST_RUN;
          w_accept = 1'b1;
        end
      end
      ST_RUN: begin
        if (halt_req || w_bp) begin
          w_next = ST_HALTED;
        end else if (step_req) begin
          w_next   = ST_STEP;
          w_accept = 1'b1;
        end
      end
      ST_STEP: begin
        // Leave once the single retire happens; a stalled step keeps waiting.
        if (halt_req || core_en) begin
          w_next = ST_HALTED;
        end
      end
      default: w_next = ST_HALTED;
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= ST_HALTED;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_wr       <= '0;
      r_rd       <= '0;
      r_retired  <= '0;
      r_overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr[AW-1:0]] <= {core_pc, core_out, core_file};
        r_wr                <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      if (core_en) begin
        r_retired <= r_retired + CNT_W'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (w_accept) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign trc_valid    = !w_empty;
  assign trc_data     = r_mem[r_rd[AW-1:0]];
  assign trc_count    = r_wr - r_rd;
  assign trc_overflow = r_overflow;
  assign retired      = r_retired;
  assign run_state    = r_state;

endmodule
`default_nettype wire
